// File: rtl/dsi_sched_pkg.sv
// Shared types for the DSI high-speed scheduler: FSM states, requester ids and strobe width.
package dsi_sched_pkg;

    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLK_UP     = 3'd1,
        ST_LINES_UP   = 3'd2,
        ST_STREAM     = 3'd3,
        ST_LINES_DOWN = 3'd4,
        ST_CLK_DOWN   = 3'd5
    } sched_state_t;

    // Encoding doubles as the request/grant bit index; a cleared history means "vid last".
    typedef enum logic {
        REQ_VID = 1'b0,
        REQ_CMD = 1'b1
    } req_id_t;

    // States where the FSM is waiting on a lane-controller ready handshake.
    function automatic logic is_wait_state(input sched_state_t s);
        return (s == ST_CLK_UP) || (s == ST_LINES_UP) ||
               (s == ST_LINES_DOWN) || (s == ST_CLK_DOWN);
    endfunction

endpackage

// File: rtl/dsi_sched_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, history updated when the scheduler accepts a grant.
module dsi_sched_rr_arb
    import dsi_sched_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    req_id_t r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[REQ_VID] && i_req[REQ_CMD]) begin
            if (r_last == REQ_CMD) begin
                o_gnt[REQ_VID] = 1'b1;
            end else begin
                o_gnt[REQ_CMD] = 1'b1;
            end
        end else begin
            o_gnt = i_req;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= REQ_VID;
        end else if (i_update && (|o_gnt)) begin
            r_last <= o_gnt[REQ_CMD] ? REQ_CMD : REQ_VID;
        end
    end

endmodule

// File: rtl/dsi_hs_scheduler.sv
// DSI HS scheduler: arbitrates video/command packets and sequences HS clock and data lane power.
// Optional ready-handshake watchdog enabled by defining DSI_SCHED_TIMEOUT_EN.
module dsi_hs_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int DATA_W       = 32
) (
    input  logic              clk_sys,
    input  logic              rst_n,

    input  logic              vid_rqst,
    input  logic              vid_last,
    input  logic [DATA_W-1:0] vid_data,
    input  logic [STRB_W-1:0] vid_strb,
    output logic              vid_ack,

    input  logic              cmd_rqst,
    input  logic              cmd_last,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              cmd_ack,

    output logic [DATA_W-1:0] iface_write_data,
    output logic [STRB_W-1:0] iface_write_strb,
    output logic              iface_write_rqst,
    output logic              iface_last_word,
    input  logic              iface_data_rqst,

    output logic              clock_enable,
    output logic              lines_enable,
    input  logic              clock_ready,
    input  logic              lines_ready,

    input  logic              reg_clk_keep_on,
    output logic              busy,
    output logic              grant_cmd,
    output logic              timeout_err
);

    sched_state_t r_state;
    logic         r_grant_cmd;
    logic         r_clk_en;
    logic         r_lines_en;

    logic [1:0]        w_gnt;
    logic              w_any_rqst;
    logic              w_stream;
    logic              w_sel_rqst;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic [STRB_W-1:0] w_sel_strb;
    logic              w_xfer;
    logic              w_wait_done;
    logic              w_timeout;

    assign w_any_rqst = vid_rqst | cmd_rqst;

    dsi_sched_rr_arb u_arb (
        .i_clk    (clk_sys),
        .i_rst_n  (rst_n),
        .i_req    ({cmd_rqst, vid_rqst}),
        .i_update (r_state == ST_IDLE),
        .o_gnt    (w_gnt)
    );

    // Granted requester is fixed for the whole packet, so the mux select is the grant register.
    assign w_sel_rqst = r_grant_cmd ? cmd_rqst : vid_rqst;
    assign w_sel_last = r_grant_cmd ? cmd_last : vid_last;
    assign w_sel_data = r_grant_cmd ? cmd_data : vid_data;
    assign w_sel_strb = r_grant_cmd ? cmd_strb : vid_strb;

    assign w_stream         = (r_state == ST_STREAM);
    assign iface_write_rqst = w_stream & w_sel_rqst;
    assign iface_last_word  = w_stream & w_sel_last;
    assign iface_write_data = w_stream ? w_sel_data : '0;
    assign iface_write_strb = w_stream ? w_sel_strb : '0;

    assign w_xfer  = iface_write_rqst & iface_data_rqst;
    assign cmd_ack = w_xfer & r_grant_cmd;
    assign vid_ack = w_xfer & ~r_grant_cmd;

    always_comb begin
        w_wait_done = 1'b0;
        case (r_state)
            ST_CLK_UP:     w_wait_done = clock_ready;
            ST_LINES_UP:   w_wait_done = lines_ready;
            ST_LINES_DOWN: w_wait_done = ~lines_ready;
            ST_CLK_DOWN:   w_wait_done = ~clock_ready;
            default:       w_wait_done = 1'b0;
        endcase
    end

`ifdef DSI_SCHED_TIMEOUT_EN
    localparam int TMO_W = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;
    logic             w_waiting;

    assign w_waiting = is_wait_state(r_state);
    assign w_timeout = w_waiting && !w_wait_done &&
                       (r_tmo_cnt == TMO_W'(WAIT_TIMEOUT - 1));

    // Counter restarts on every state change so each handshake gets its own budget.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (!w_waiting || w_wait_done || w_timeout) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_timeout) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_tmo_err;
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = WAIT_TIMEOUT;
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_cmd <= 1'b0;
            r_clk_en    <= 1'b0;
            r_lines_en  <= 1'b0;
        end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_clk_en   <= 1'b0;
            r_lines_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_rqst) begin
                        r_grant_cmd <= w_gnt[REQ_CMD];
                        // HS clock still running from a kept-on previous packet: skip clock bring-up.
                        if (r_clk_en && clock_ready) begin
                            r_state    <= ST_LINES_UP;
                            r_lines_en <= 1'b1;
                        end else begin
                            r_state  <= ST_CLK_UP;
                            r_clk_en <= 1'b1;
                        end
                    end
                end
                ST_CLK_UP: begin
                    if (w_wait_done) begin
                        r_state    <= ST_LINES_UP;
                        r_lines_en <= 1'b1;
                    end
                end
                ST_LINES_UP: begin
                    if (w_wait_done) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer && w_sel_last) begin
                        r_state    <= ST_LINES_DOWN;
                        r_lines_en <= 1'b0;
                    end
                end
                ST_LINES_DOWN: begin
                    if (w_wait_done) begin
                        if (reg_clk_keep_on) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state  <= ST_CLK_DOWN;
                            r_clk_en <= 1'b0;
                        end
                    end
                end
                ST_CLK_DOWN: begin
                    if (w_wait_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign clock_enable = r_clk_en;
    assign lines_enable = r_lines_en;
    assign grant_cmd    = r_grant_cmd;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dsi_hs_scheduler.sv
// Self-checking bench for dsi_hs_scheduler: directed scenarios plus randomized packet traffic
// scored against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_dsi_hs_scheduler;

`ifdef DSI_SCHED_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 255;
`endif
    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [3:0]        strb;
        logic              last;
    } word_t;

    logic              clk_sys, rst_n;
    logic              vid_rqst, vid_last, vid_ack;
    logic [DATA_W-1:0] vid_data;
    logic [3:0]        vid_strb;
    logic              cmd_rqst, cmd_last, cmd_ack;
    logic [DATA_W-1:0] cmd_data;
    logic [3:0]        cmd_strb;
    logic [DATA_W-1:0] iface_write_data;
    logic [3:0]        iface_write_strb;
    logic              iface_write_rqst, iface_last_word, iface_data_rqst;
    logic              clock_enable, lines_enable, clock_ready, lines_ready;
    logic              reg_clk_keep_on, busy, grant_cmd, timeout_err;

    dsi_hs_scheduler #(.WAIT_TIMEOUT(TB_TMO), .DATA_W(DATA_W)) dut (
        .clk_sys          (clk_sys),
        .rst_n            (rst_n),
        .vid_rqst         (vid_rqst),
        .vid_last         (vid_last),
        .vid_data         (vid_data),
        .vid_strb         (vid_strb),
        .vid_ack          (vid_ack),
        .cmd_rqst         (cmd_rqst),
        .cmd_last         (cmd_last),
        .cmd_data         (cmd_data),
        .cmd_strb         (cmd_strb),
        .cmd_ack          (cmd_ack),
        .iface_write_data (iface_write_data),
        .iface_write_strb (iface_write_strb),
        .iface_write_rqst (iface_write_rqst),
        .iface_last_word  (iface_last_word),
        .iface_data_rqst  (iface_data_rqst),
        .clock_enable     (clock_enable),
        .lines_enable     (lines_enable),
        .clock_ready      (clock_ready),
        .lines_ready      (lines_ready),
        .reg_clk_keep_on  (reg_clk_keep_on),
        .busy             (busy),
        .grant_cmd        (grant_cmd),
        .timeout_err      (timeout_err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Requester / lane-controller stimulus state
    word_t vq[$], cq[$];
    bit    v_in_pkt, c_in_pkt, v_ack_s, c_ack_s;
    bit    gap_en, drq_rand, drq_low, hold_clk_low;
    int    clk_dly, lines_dly, c_cnt, l_cnt;

    // Reference model: pending packets per requester and round-robin history
    word_t m_vq[$], m_cq[$];
    bit    m_in_pkt, m_src_cmd, m_last_cmd;

    task automatic load_pkt(input bit is_cmd, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = $urandom;
            w.strb = 4'($urandom_range(1, 15));
            w.last = (i == n - 1);
            if (is_cmd) begin cq.push_back(w); m_cq.push_back(w); end
            else        begin vq.push_back(w); m_vq.push_back(w); end
        end
    endtask

    always begin
        @(posedge clk_sys);
        #1;
        if (!rst_n) begin
            vid_rqst = 0; cmd_rqst = 0; vid_last = 0; cmd_last = 0;
            clock_ready = 0; lines_ready = 0; c_cnt = 0; l_cnt = 0;
            v_in_pkt = 0; c_in_pkt = 0; v_ack_s = 0; c_ack_s = 0;
        end else begin
            if (v_ack_s && vq.size() > 0) begin v_in_pkt = !vq[0].last; vq.delete(0); end
            if (c_ack_s && cq.size() > 0) begin c_in_pkt = !cq[0].last; cq.delete(0); end
            v_ack_s = 0; c_ack_s = 0;
            if (vq.size() > 0) begin
                vid_rqst = !(v_in_pkt && gap_en && ($urandom_range(0, 5) == 0));
                vid_data = vq[0].data; vid_strb = vq[0].strb; vid_last = vq[0].last;
            end else begin
                vid_rqst = 0; vid_data = '0; vid_strb = '0; vid_last = 0;
            end
            if (cq.size() > 0) begin
                cmd_rqst = !(c_in_pkt && gap_en && ($urandom_range(0, 5) == 0));
                cmd_data = cq[0].data; cmd_strb = cq[0].strb; cmd_last = cq[0].last;
            end else begin
                cmd_rqst = 0; cmd_data = '0; cmd_strb = '0; cmd_last = 0;
            end
            iface_data_rqst = drq_low ? 1'b0 : (drq_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (hold_clk_low) begin
                clock_ready = 0; c_cnt = 0;
            end else if (clock_enable != clock_ready) begin
                if (c_cnt + 1 >= clk_dly) begin clock_ready = clock_enable; c_cnt = 0; end
                else c_cnt++;
            end else c_cnt = 0;
            if (lines_enable != lines_ready) begin
                if (l_cnt + 1 >= lines_dly) begin lines_ready = lines_enable; l_cnt = 0; end
                else l_cnt++;
            end else l_cnt = 0;
        end
    end

    task automatic model_word();
        word_t w;
        if (!m_in_pkt) begin
            if (m_cq.size() > 0 && m_vq.size() > 0) m_src_cmd = !m_last_cmd;
            else                                   m_src_cmd = (m_cq.size() > 0);
            m_last_cmd = m_src_cmd;
            m_in_pkt   = 1;
        end
        chk("xfer_grant", 64'(grant_cmd), 64'(m_src_cmd));
        chk("xfer_ack", 64'({cmd_ack, vid_ack}), m_src_cmd ? 64'd2 : 64'd1);
        chk("xfer_enables", 64'({clock_enable, lines_enable, busy}), 64'd7);
        if ((m_src_cmd ? m_cq.size() : m_vq.size()) == 0) begin
            chk("spurious_xfer", 64'd1, 64'd0);
            m_in_pkt = 0;
        end else begin
            if (m_src_cmd) begin w = m_cq[0]; m_cq.delete(0); end
            else           begin w = m_vq[0]; m_vq.delete(0); end
            chk("xfer_data", 64'(iface_write_data), 64'(w.data));
            chk("xfer_strb", 64'(iface_write_strb), 64'(w.strb));
            chk("xfer_last", 64'(iface_last_word), 64'(w.last));
            if (w.last) m_in_pkt = 0;
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_n) begin
            v_ack_s = vid_ack;
            c_ack_s = cmd_ack;
            if (iface_write_rqst && iface_data_rqst) model_word();
        end
    end

    task automatic assert_rst();
        rst_n = 0;
        vq.delete(); cq.delete(); m_vq.delete(); m_cq.delete();
        m_in_pkt = 0; m_last_cmd = 0;
        v_in_pkt = 0; c_in_pkt = 0; v_ack_s = 0; c_ack_s = 0;
        vid_rqst = 0; cmd_rqst = 0; vid_last = 0; cmd_last = 0;
        clock_ready = 0; lines_ready = 0;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk_sys);
        #2 rst_n = 1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk_sys);
            if (vq.size() == 0 && cq.size() == 0 && !busy) done = 1;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  t_clk, t_lines, n_ack, n_vack, n_lastp, cyc, drops, rises, k;
        bit  last3, seen_on, prev_lines, done;
        bit  g[4];
        logic [DATA_W-1:0] exp_w1;

        vid_data = '0; vid_strb = '0; cmd_data = '0; cmd_strb = '0;
        iface_data_rqst = 1; reg_clk_keep_on = 0;
        gap_en = 0; drq_rand = 0; drq_low = 0; hold_clk_low = 0;
        clk_dly = 2; lines_dly = 2;
        assert_rst();
        release_rst();
        @(negedge clk_sys);
        chk("rst_ctrl", 64'({clock_enable, lines_enable, busy, grant_cmd, vid_ack, cmd_ack,
                             iface_write_rqst, iface_last_word, timeout_err}), 64'd0);
        chk("rst_data", 64'({iface_write_data, iface_write_strb}), 64'd0);

        // 3-word cmd packet, readies answer after 2 cycles
        load_pkt(1, 3);
        t_clk = -1; t_lines = -1; n_ack = 0; n_vack = 0; n_lastp = 0; last3 = 0; done = 0;
        for (cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk_sys);
            if (clock_enable && t_clk < 0) t_clk = cyc;
            if (lines_enable && t_lines < 0) t_lines = cyc;
            if (vid_ack) n_vack++;
            if (cmd_ack) begin
                n_ack++;
                if (iface_last_word) n_lastp++;
                if (n_ack == 3) last3 = iface_last_word;
            end
            if (n_ack == 3 && !busy) done = 1;
        end
        chk("p1_clk_then_lines", 64'(t_clk >= 0 && t_lines - t_clk == 2), 64'd1);
        chk("p1_cmd_acks", 64'(n_ack), 64'd3);
        chk("p1_vid_acks", 64'(n_vack), 64'd0);
        chk("p1_last_on_w3", 64'({last3, 4'(n_lastp)}), 64'h11);
        chk("p1_end_state", 64'({clock_enable, lines_enable, busy}), 64'd0);

        // Simultaneous requests right after reset: cmd first, then vid
        assert_rst();
        release_rst();
        load_pkt(0, 2);
        load_pkt(1, 2);
        n_ack = 0;
        for (int i = 0; i < 300 && n_ack < 4; i++) begin
            @(negedge clk_sys);
            if (vid_ack || cmd_ack) begin g[n_ack] = grant_cmd; n_ack++; end
        end
        chk("rr_acks", 64'(n_ack), 64'd4);
        chk("rr_first_cmd", 64'({g[0], g[1]}), 64'd3);
        chk("rr_second_vid", 64'({g[2], g[3]}), 64'd0);
        wait_idle(200, "rr_drain");

        // Keep-on: two back-to-back vid packets never drop the HS clock
        reg_clk_keep_on = 1;
        load_pkt(0, 3);
        load_pkt(0, 2);
        seen_on = 0; drops = 0; rises = 0; prev_lines = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_sys);
            if (clock_enable) seen_on = 1;
            else if (seen_on) drops++;
            if (lines_enable && !prev_lines) rises++;
            prev_lines = lines_enable;
            if (vq.size() == 0 && !busy) done = 1;
        end
        chk("keep_done", 64'(done), 64'd1);
        chk("keep_no_clk_drop", 64'(drops), 64'd0);
        chk("keep_two_lines_up", 64'(rises), 64'd2);
        chk("keep_clk_held", 64'({clock_enable, lines_enable}), 64'd2);
        reg_clk_keep_on = 0;

        // Lane controller stalls for 5 cycles mid-packet
        load_pkt(1, 4);
        exp_w1 = cq[1].data;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_sys);
            if (cmd_ack) done = 1;
        end
        chk("stall_first_ack", 64'(done), 64'd1);
        drq_low = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            chk("stall_no_ack", 64'({cmd_ack, vid_ack}), 64'd0);
            chk("stall_data", 64'(iface_write_data), 64'(exp_w1));
            chk("stall_in_stream", 64'({iface_write_rqst, lines_enable, busy}), 64'd7);
        end
        drq_low = 0;
        wait_idle(200, "stall_drain");

        // Asynchronous reset in the middle of a packet
        load_pkt(0, 4);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_sys);
            if (vid_ack) done = 1;
        end
        chk("mid_rst_in_stream", 64'(done), 64'd1);
        #2 assert_rst();
        #1;
        chk("mid_rst_ctrl", 64'({clock_enable, lines_enable, busy, grant_cmd, vid_ack, cmd_ack,
                                 iface_write_rqst, iface_last_word, timeout_err}), 64'd0);
        chk("mid_rst_data", 64'({iface_write_data, iface_write_strb}), 64'd0);
        release_rst();
        load_pkt(1, 2);
        t_clk = -1; t_lines = -1;
        for (int i = 0; i < 100 && t_lines < 0; i++) begin
            @(negedge clk_sys);
            if (clock_enable && t_clk < 0) t_clk = i;
            if (lines_enable && t_lines < 0) t_lines = i;
        end
        chk("restart_clk_up", 64'(t_clk >= 0 && t_lines > t_clk), 64'd1);
        wait_idle(200, "restart_drain");

`ifdef DSI_SCHED_TIMEOUT_EN
        // Clock never reports ready: watchdog fires after WAIT_TIMEOUT cycles
        assert_rst();
        release_rst();
        hold_clk_low = 1;
        load_pkt(1, 1);
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_sys);
            if (clock_enable) done = 1;
        end
        chk("tmo_clk_up", 64'(done), 64'd1);
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            @(negedge clk_sys);
            if (timeout_err) k = i;
        end
        chk("tmo_cycles", 64'(k), 64'd16);
        chk("tmo_state", 64'({timeout_err, clock_enable, lines_enable, busy}), 64'h8);
        hold_clk_low = 0;
        assert_rst();
        release_rst();
        @(negedge clk_sys);
        chk("tmo_cleared_by_rst", 64'(timeout_err), 64'd0);
`endif

        // Randomized traffic against the round-robin model
        for (int r = 0; r < 8; r++) begin
            int nv, nc;
            clk_dly = $urandom_range(0, 3);
            lines_dly = $urandom_range(0, 3);
            reg_clk_keep_on = 1'($urandom_range(0, 1));
            gap_en = 1; drq_rand = 1;
            nv = $urandom_range(0, 3);
            nc = $urandom_range(0, 3);
            if (nv == 0 && nc == 0) nv = 1;
            for (int i = 0; i < nv; i++) load_pkt(0, $urandom_range(1, 6));
            for (int i = 0; i < nc; i++) load_pkt(1, $urandom_range(1, 6));
            wait_idle(3000, "rand_drain");
            chk("rand_model_empty", 64'(m_vq.size() + m_cq.size()), 64'd0);
        end
        chk("no_timeout_err", 64'(timeout_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dsi_hs_scheduler.md
DSI_HS_SCHEDULER -- requirements
Module: dsi_hs_scheduler

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255: max cycles waiting on a ready handshake.
REQ-002 SHALL have parameter DATA_W, default 32: data word width.
REQ-003 SHALL have port clk_sys  in  1  the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports vid_rqst/vid_last  in  1, vid_data  in  DATA_W, vid_strb  in  4, vid_ack  out  1: video requester.
REQ-006 SHALL have ports cmd_rqst/cmd_last  in  1, cmd_data  in  DATA_W, cmd_strb  in  4, cmd_ack  out  1: command requester.
REQ-007 SHALL have ports iface_write_data  out  DATA_W, iface_write_strb  out  4, iface_write_rqst  out  1, iface_last_word  out  1, iface_data_rqst  in  1: lanes-controller word interface.
REQ-008 SHALL have ports clock_enable/lines_enable  out  1, clock_ready/lines_ready  in  1: lane power sequencing.
REQ-009 SHALL have ports reg_clk_keep_on  in  1 (hold HS clock between packets), busy  out  1, grant_cmd  out  1, timeout_err  out  1 (sticky).

Function
REQ-010 SHALL implement FSM states IDLE, CLK_UP, LINES_UP, STREAM, LINES_DOWN, CLK_DOWN.
REQ-011 IDLE: when vid_rqst or cmd_rqst, latch grant, go CLK_UP; go directly to LINES_UP if clock_enable and clock_ready are already 1.
REQ-012 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset cmd wins first.
REQ-013 CLK_UP: clock_enable=1; go LINES_UP the cycle after clock_ready=1.
REQ-014 LINES_UP: lines_enable=1; go STREAM the cycle after lines_ready=1.
REQ-015 STREAM: iface_write_data/strb/last_word/rqst SHALL be combinational copies of the granted requester's data/strb/last/rqst; all are 0 outside STREAM.
REQ-016 A word transfers when iface_write_rqst and iface_data_rqst are both 1; the granted requester's ack equals that term; the other ack is 0.
REQ-017 Requester deasserting rqst mid-packet SHALL stall in STREAM with no state change.
REQ-018 A transfer with last=1 SHALL move the FSM to LINES_DOWN on the next edge; lines_enable=0 from that cycle.
REQ-019 LINES_DOWN: wait lines_ready=0, then CLK_DOWN if reg_clk_keep_on=0, else IDLE with clock_enable held 1.
REQ-020 CLK_DOWN: clock_enable=0; wait clock_ready=0, then IDLE.
REQ-021 grant_cmd SHALL be registered and stable from CLK_UP through CLK_DOWN; busy=1 in every state except IDLE.
REQ-022 New requests arriving outside IDLE SHALL be held off (ack 0) until IDLE re-arbitrates.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE and set all outputs, grant history, timeout counter and timeout_err to 0, including mid-packet.

Configuration
REQ-024 With DSI_SCHED_TIMEOUT_EN defined, an 8+-bit counter SHALL count cycles in CLK_UP, LINES_UP, LINES_DOWN, CLK_DOWN and clear on each state change.
REQ-025 On reaching WAIT_TIMEOUT it SHALL set timeout_err, drop clock_enable and lines_enable, and return to IDLE; timeout_err clears only on reset.
REQ-026 Without DSI_SCHED_TIMEOUT_EN, no counter SHALL exist, waits are unbounded, and timeout_err is tied 0.

Structure
REQ-027 Package dsi_sched_pkg SHALL hold the FSM state enum, the requester-id enum (REQ_VID, REQ_CMD) and the strobe width constant.
REQ-028 Round-robin selection SHALL live in sub-module dsi_sched_rr_arb (2 requests, last-grant register, one-hot grant).

Verification
REQ-029 cmd packet of 3 words, readies answering after 2 cycles -> clock_enable, then lines_enable, then 3 cmd_ack pulses, iface_last_word on word 3, then both enables drop; busy=0 at the end.
REQ-030 vid_rqst and cmd_rqst both 1 after reset -> cmd granted first and vid second (grant_cmd 1 then 0).
REQ-031 reg_clk_keep_on=1 with two back-to-back vid packets -> clock_enable stays 1 throughout; the second packet enters LINES_UP with no CLK_UP.
REQ-032 iface_data_rqst held 0 for 5 cycles mid-packet -> no ack, iface_write_data stable, no state change.
REQ-033 DSI_SCHED_TIMEOUT_EN, WAIT_TIMEOUT=16, clock_ready never rises -> timeout_err=1 after 16 cycles, enables 0, IDLE.
REQ-034 rst_n low in STREAM -> all outputs 0 immediately (async); after release the next request restarts at CLK_UP.
